mult_arbiter: RTL and testbench

Shares the single sequential signed multiplier between independent requesters: the envelope generator, the sample controller (voice×envelope and master-volume products) and the SVF. A request/acknowledge handshake per requester lets the arbiter select one, register its operands, pulse the multiplier start, and wait for completion. It then returns the 40-bit product with a one-cycle acknowledge. It replaces the OR-ed start lines and static operand mux in front of the multiplier.

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/mult_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 32 +++
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_mult_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier arbiter.
//   - arb_state_e : arbiter FSM states
//   - *_DEF       : default requester count and operand widths
//   - REQ_*       : requester index assignment
package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam int NUM_REQ_DEF = 3;
   localparam int A_W_DEF     = 24;
   localparam int B_W_DEF     = 16;

   localparam int REQ_ENV  = 0;
   localparam int REQ_CTRL = 1;
   localparam int REQ_SVF  = 2;

endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester-side bus of the multiplier arbiter.
//   req_i   per-requester request level
//   op_a_i  per-requester operand A (signed, A_W bits each)
//   op_b_i  per-requester operand B (signed, B_W bits each)
//   flush_i synchronous abort of the current transaction
//   gnt_o   one-hot grant, ISSUE through DONE
//   ack_o   one-hot one-cycle pulse when prod_o is valid
//   prod_o  registered product
//   busy_o  arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface mult_arbiter_if
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int A_W     = A_W_DEF,
   parameter int B_W     = B_W_DEF
);
   logic [NUM_REQ-1:0]          req_i;
   logic [NUM_REQ-1:0][A_W-1:0] op_a_i;
   logic [NUM_REQ-1:0][B_W-1:0] op_b_i;
   logic                        flush_i;
   logic [NUM_REQ-1:0]          gnt_o;
   logic [NUM_REQ-1:0]          ack_o;
   logic signed [A_W+B_W-1:0]   prod_o;
   logic                        busy_o;

   modport master (
      output req_i, op_a_i, op_b_i, flush_i,
      input  gnt_o, ack_o, prod_o, busy_o
   );

   modport slave (
      input  req_i, op_a_i, op_b_i, flush_i,
      output gnt_o, ack_o, prod_o, busy_o
   );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational request picker.
//   req_i   request vector
//   start_i index that has highest priority; priority falls off
//           cyclically from there (start_i = 0 gives fixed priority)
//   valid_o at least one request present
//   idx_o   winning index
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);
   logic [IDX_W-1:0] pos;

   // Scan from the lowest priority position back to start_i so that the
   // last hit, which overrides earlier ones, is the highest priority one.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = IDX_W'((int'(start_i) + k) % N);
         if (req_i[pos]) begin
            valid_o = 1'b1;
            idx_o   = pos;
         end
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential signed multiplier between NUM_REQ
// requesters (0 = envelope, 1 = controller, 2 = SVF).
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   bus             requester bus (mult_arbiter_if.slave)
//   mult_start_o    one-cycle start pulse to the multiplier
//   mult_a_o/_b_o   registered operands to the multiplier
//   mult_ready_i    one-cycle completion pulse from the multiplier
//   mult_prod_i     product, valid with mult_ready_i
// Build option: define MULT_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int A_W     = A_W_DEF,
   parameter int B_W     = B_W_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   mult_arbiter_if.slave             bus,
   output logic                      mult_start_o,
   output logic signed [A_W-1:0]     mult_a_o,
   output logic signed [B_W-1:0]     mult_b_o,
   input  logic                      mult_ready_i,
   input  logic signed [A_W+B_W-1:0] mult_prod_i
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int P_W   = A_W + B_W;

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic signed [P_W-1:0]  prod_q, prod_d;
   logic signed [A_W-1:0]  a_q, a_d;
   logic signed [B_W-1:0]  b_q, b_d;
   logic                   start_q, start_d;
   logic                   busy_q, busy_d;

   logic                   pick_vld;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       pick_start;

`ifdef MULT_ARB_RR_EN
   // Pointer holds the last winner that reached DONE; flushed
   // transactions leave it alone so the same requester wins again.
   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == WAIT && mult_ready_i && !bus.flush_i) ptr_d = owner_q;
   end

   assign pick_start = (ptr_q == IDX_W'(NUM_REQ - 1)) ? '0 : ptr_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= IDX_W'(NUM_REQ - 1);
      else         ptr_q <= ptr_d;
   end
`else
   assign pick_start = '0;
`endif

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req_i   (bus.req_i),
      .start_i (pick_start),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      prod_d  = prod_q;
      a_d     = a_q;
      b_d     = b_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick_idx;
               a_d     = bus.op_a_i[pick_idx];
               b_d     = bus.op_b_i[pick_idx];
               gnt_d   = NUM_REQ'(1) << pick_idx;
               start_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (mult_ready_i) begin
               prod_d  = mult_prod_i;
               ack_d   = NUM_REQ'(1) << owner_q;
               state_d = DONE;
            end
         end
         DONE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Flush overrides everything, including a same-cycle mult_ready_i.
      // The multiplier keeps running; its late ready lands outside WAIT.
      if (bus.flush_i) begin
         state_d = IDLE;
         owner_d = owner_q;
         gnt_d   = '0;
         ack_d   = '0;
         prod_d  = prod_q;
         a_d     = a_q;
         b_d     = b_q;
         start_d = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         prod_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         prod_q  <= prod_d;
         a_q     <= a_d;
         b_q     <= b_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt_o    = gnt_q;
   assign bus.ack_o    = ack_q;
   assign bus.prod_o   = prod_q;
   assign bus.busy_o   = busy_q;
   assign mult_start_o = start_q;
   assign mult_a_o     = a_q;
   assign mult_b_o     = b_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a latency-L
// multiplier model. Follows MULT_ARB_RR_EN for arbitration expectations.
module tb_mult_arbiter;
   import mult_arb_pkg::*;

   typedef struct packed {
      logic [2:0]         ack;
      logic signed [39:0] prod;
   } exp_t;

   logic clk;
   logic rst_ni;
   logic mult_start;
   logic signed [23:0] mult_a;
   logic signed [15:0] mult_b;
   logic mult_ready;
   logic signed [39:0] mult_prod;

   int n_vec = 0;
   int n_err = 0;
   int unsigned lat = 10;
   int unsigned stray_req = 0;
   int unsigned stray_done = 0;
   int ptr_m = 2;
   logic signed [39:0] prod_last = '0;
   exp_t sb_q[$];

   mult_arbiter_if #(.NUM_REQ(3), .A_W(24), .B_W(16)) bus ();

   mult_arbiter #(.NUM_REQ(3), .A_W(24), .B_W(16)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .mult_start_o (mult_start),
      .mult_a_o     (mult_a),
      .mult_b_o     (mult_b),
      .mult_ready_i (mult_ready),
      .mult_prod_i  (mult_prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Multiplier model: ready L cycles after start, plus on-demand stray pulses.
   initial begin
      int cnt;
      logic signed [23:0] pa;
      logic signed [15:0] pb;
      cnt = 0; pa = '0; pb = '0;
      mult_ready = 1'b0; mult_prod = '0;
      forever begin
         @(posedge clk); #1;
         mult_ready = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mult_ready = 1'b1;
               mult_prod  = 40'(pa) * 40'(pb);
            end
         end else if (stray_req != stray_done) begin
            stray_done = stray_req;
            mult_ready = 1'b1;
            mult_prod  = 40'sh55_AAAA_1234;
         end
         if (mult_start) begin
            pa  = mult_a;
            pb  = mult_b;
            cnt = int'(lat);
         end
      end
   end

   // Scoreboard consumer: every ack must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_ni) prod_last = '0;
         else if (bus.ack_o != '0) begin
            if (sb_q.size() == 0) begin
               check_val("ack_unexpected", 64'(bus.ack_o), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("sb_ack", 64'(bus.ack_o), 64'(e.ack));
               check_val("sb_prod", bus.prod_o, e.prod);
               prod_last = e.prod;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

   function automatic int model_pick(input logic [2:0] rq);
`ifdef MULT_ARB_RR_EN
      for (int k = 1; k <= 3; k++) if (rq[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
`else
      for (int i = 0; i < 3; i++) if (rq[i]) return i;
`endif
      return 0;
   endfunction

   task automatic set_op(input int idx, input logic signed [23:0] a, input logic signed [15:0] b);
      bus.op_a_i[idx] = a;
      bus.op_b_i[idx] = b;
   endtask

   task automatic wait_ack(input string tag, input int exp_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.ack_o == '0 && n < 300);
      check_val(tag, 64'(n), 64'(exp_cyc));
   endtask

   task automatic do_txn(input string tag, input logic [2:0] rq, input int exp_cyc, input int w);
      exp_t e;
      e.ack  = 3'b001 << w;
      e.prod = 40'($signed(bus.op_a_i[w])) * 40'($signed(bus.op_b_i[w]));
      sb_q.push_back(e);
      bus.req_i = rq;
      wait_ack(tag, exp_cyc);
      ptr_m = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.req_i = '0; bus.flush_i = 1'b0; rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_ni = 1'b1;
      ptr_m = 2;
   endtask

   initial begin
      int seq [4];
      int w;
      exp_t e;
      rst_ni = 1'b0;
      bus.req_i = '0; bus.op_a_i = '0; bus.op_b_i = '0; bus.flush_i = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_ni = 1'b1;
      @(negedge clk);
      check_val("rst_gnt",   64'(bus.gnt_o), 64'd0);
      check_val("rst_ack",   64'(bus.ack_o), 64'd0);
      check_val("rst_prod",  bus.prod_o, 64'd0);
      check_val("rst_busy",  64'(bus.busy_o), 64'd0);
      check_val("rst_start", 64'(mult_start), 64'd0);
      check_val("rst_a",     mult_a, 64'd0);
      check_val("rst_b",     mult_b, 64'd0);

      // Single request from the controller, L = 10.
      lat = 10;
      set_op(REQ_CTRL, -24'sd300, 16'sd200);
      e.ack = 3'b010; e.prod = -40'sd60000;
      sb_q.push_back(e);
      bus.req_i = 3'b010;
      @(negedge clk);
      check_val("t1_start", 64'(mult_start), 64'd1);
      check_val("t1_mult_a", mult_a, -24'sd300);
      check_val("t1_mult_b", mult_b, 16'sd200);
      check_val("t1_gnt", 64'(bus.gnt_o), 64'b010);
      @(negedge clk);
      check_val("t1_start_pulse", 64'(mult_start), 64'd0);
      check_val("t1_busy", 64'(bus.busy_o), 64'd1);
      wait_ack("t1_ack_cycle", 10);
      check_val("t1_gnt_done", 64'(bus.gnt_o), 64'b010);
      bus.req_i = '0;
      ptr_m = REQ_CTRL;
      @(negedge clk);
      check_val("t1_ack_pulse", 64'(bus.ack_o), 64'd0);
      check_val("t1_gnt_clr", 64'(bus.gnt_o), 64'd0);
      check_val("t1_prod_hold", bus.prod_o, -40'sd60000);

      // All three requesting, L = 4.
      do_reset();
      lat = 4;
      set_op(REQ_ENV, 24'sd1000, -16'sd7);
      set_op(REQ_CTRL, 24'sh800000, 16'sh8000);
      set_op(REQ_SVF, 24'sd12345, -16'sd1);
`ifdef MULT_ARB_RR_EN
      seq = '{0, 1, 2, 0};
`else
      seq = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      do_txn("t2_ack0_cycle", 3'b111, 6, seq[0]);
      for (int i = 1; i < 4; i++) do_txn($sformatf("t2_ack%0d_cycle", i), 3'b111, 7, seq[i]);
      do_txn("t2_drop0_cycle", 3'b110, 7, REQ_CTRL);
      bus.req_i = '0;

      // Operand isolation: requester changes operands during WAIT.
      @(negedge clk);
      lat = 8;
      set_op(REQ_ENV, 24'sh7FFFFF, 16'sh7FFF);
      e.ack = 3'b001; e.prod = 40'sh3F_FF7F_8001;
      sb_q.push_back(e);
      bus.req_i = 3'b001;
      repeat (2) @(negedge clk);
      set_op(REQ_ENV, -24'sd5, 16'sd3);
      @(negedge clk);
      check_val("t3_mult_a_held", mult_a, 24'sh7FFFFF);
      check_val("t3_mult_b_held", mult_b, 16'sh7FFF);
      wait_ack("t3_ack_cycle", 7);
      bus.req_i = '0;
      ptr_m = REQ_ENV;

      // Flush in WAIT coinciding with mult_ready.
      @(negedge clk);
      lat = 5;
      set_op(REQ_ENV, 24'sd77, -16'sd3);
      set_op(REQ_CTRL, -24'sd1000, -16'sd1000);
      w = model_pick(3'b011);
      bus.req_i = 3'b011;
      @(negedge clk);
      check_val("t4_gnt_first", 64'(bus.gnt_o), 64'(3'b001 << w));
      repeat (5) @(posedge clk);
      #1 bus.flush_i = 1'b1;
      @(posedge clk);
      #1 bus.flush_i = 1'b0;
      @(negedge clk);
      check_val("t4_flush_ack", 64'(bus.ack_o), 64'd0);
      check_val("t4_flush_busy", 64'(bus.busy_o), 64'd0);
      check_val("t4_flush_gnt", 64'(bus.gnt_o), 64'd0);
      check_val("t4_flush_prod", bus.prod_o, prod_last);
      do_txn("t4_retry_cycle", 3'b011, 7, w);
      bus.req_i = '0;

      // Stray mult_ready while idle.
      @(negedge clk);
      stray_req++;
      repeat (3) @(negedge clk);
      check_val("t5_stray_ack", 64'(bus.ack_o), 64'd0);
      check_val("t5_stray_busy", 64'(bus.busy_o), 64'd0);
      check_val("t5_stray_prod", bus.prod_o, prod_last);

      // Asynchronous reset during WAIT.
      lat = 10;
      set_op(REQ_SVF, 24'sd4096, 16'sd4096);
      bus.req_i = 3'b100;
      repeat (3) @(negedge clk);
      check_val("t6_busy_pre", 64'(bus.busy_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check_val("t6_rst_gnt", 64'(bus.gnt_o), 64'd0);
      check_val("t6_rst_busy", 64'(bus.busy_o), 64'd0);
      check_val("t6_rst_prod", bus.prod_o, 64'd0);
      check_val("t6_rst_a", mult_a, 64'd0);
      check_val("t6_rst_b", mult_b, 64'd0);
      check_val("t6_rst_start", 64'(mult_start), 64'd0);
      bus.req_i = '0;
      @(negedge clk);
      #2 rst_ni = 1'b1;
      ptr_m = 2;

      // Let the orphaned multiplier completion land in IDLE, then run again.
      repeat (12) @(negedge clk);
      lat = 3;
      set_op(REQ_ENV, -24'sd2, 16'sd21);
      do_txn("t7_post_rst_cycle", 3'b101, 5, model_pick(3'b101));
      bus.req_i = '0;

      repeat (5) @(negedge clk);
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
